cw_encoder_stream: RTL



---
 rtl/cw_encoder_stream_if.sv | 30 +++
 rtl/cw_encoder_stream.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cw_encoder_stream_if.sv
// Stream bundle for the constant-weight encoder: control, message-bit input
// stream, position output stream and the assembled codeword.
interface cw_encoder_stream_if #(
   parameter int N  = 20,
   parameter int NW = $clog2(N + 1)
);
   logic          start;
   logic          in_bit;
   logic          in_valid;
   logic          in_ready;
   logic          pos_valid;
   logic          pos_ready;
   logic [NW-1:0] pos;
   logic          pos_last;
   logic          busy;
   logic          done;
   logic [N-1:0]  cw_word;

   // Drives the encoder: message source and position sink side.
   modport master (
      output start, in_bit, in_valid, pos_ready,
      input  in_ready, pos_valid, pos, pos_last, busy, done, cw_word
   );

   // The encoder itself.
   modport slave (
      input  start, in_bit, in_valid, pos_ready,
      output in_ready, pos_valid, pos, pos_last, busy, done, cw_word
   );
endinterface

// File: rtl/cw_encoder_stream.sv
// Constant-weight encoder: consumes a serial message and emits the T
// one-positions of an N-bit weight-T word in ascending order, using the
// binary-approximation recursion with gap step 2^u. Both sides are
// valid/ready streams; the finished word is also presented in parallel.
module cw_encoder_stream #(
   parameter int N  = 20,
   parameter int T  = 8,
   parameter int NW = $clog2(N + 1),
   parameter int TW = $clog2(T + 1)
) (
   input  logic               clk,
   input  logic               rst_b,
   cw_encoder_stream_if.slave bus
);
   localparam int UW = $clog2(NW + 1);
   localparam logic [N-1:0] CW_ONE = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CALC  = 3'd1,
      S_FLAG  = 3'd2,
      S_INDEX = 3'd3,
      S_EMIT  = 3'd4,
      S_FILL  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t        r_state;
   logic [NW-1:0] r_n;        // remaining length
   logic [TW-1:0] r_t;        // remaining weight
   logic [NW-1:0] r_base;     // next free index
   logic [NW-1:0] r_delta;    // gaps skipped since the last one
   logic [UW-1:0] r_u;        // index width for the current step
   logic [NW-1:0] r_i;        // index shift register
   logic [NW-1:0] r_k;        // index bit counter / fill counter
   logic [NW-1:0] r_pos;
   logic          r_pos_valid;
   logic          r_pos_last;
   logic          r_in_ready;
   logic          r_busy;
   logic          r_done;
   logic [N-1:0]  r_cw_word;

   logic [2*NW-1:0] w_t_wide;
   logic [2*NW-1:0] w_n_wide;
   logic [UW-1:0]   w_u;
   logic [NW-1:0]   w_step;
   logic [NW-1:0]   w_gap_base;
   logic [NW-1:0]   w_i_shift;
   logic            w_in_fire;
   logic            w_pos_fire;

   // Double-width operands so t << u can never wrap during the search.
   assign w_t_wide   = {{NW{1'b0}}, NW'(r_t)};
   assign w_n_wide   = {{NW{1'b0}}, r_n};
   assign w_step     = NW'(1) << r_u;
   assign w_gap_base = r_base + r_delta;
   assign w_i_shift  = {r_i[NW-2:0], bus.in_bit};
   assign w_in_fire  = r_in_ready & bus.in_valid;
   assign w_pos_fire = r_pos_valid & bus.pos_ready;

   // Largest u with (t << u) <= n; the condition is monotonic in u, so the last hit wins.
   always_comb begin
      w_u = '0;
      for (int j = 0; j < NW; j++) begin
         if ((w_t_wide << j) <= w_n_wide) begin
            w_u = UW'(j);
         end
      end
   end

   // Encoder FSM with all stream outputs registered alongside the state.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state     <= S_IDLE;
         r_n         <= '0;
         r_t         <= '0;
         r_base      <= '0;
         r_delta     <= '0;
         r_u         <= '0;
         r_i         <= '0;
         r_k         <= '0;
         r_pos       <= '0;
         r_pos_valid <= 1'b0;
         r_pos_last  <= 1'b0;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_cw_word   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_n       <= NW'(N);
                  r_t       <= TW'(T);
                  r_base    <= '0;
                  r_delta   <= '0;
                  r_cw_word <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= S_CALC;
               end
            end

            S_CALC: begin
               if (r_t == '0) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_n <= NW'(r_t)) begin
                  // Only t indices remain and all of them must be ones.
                  r_k         <= '0;
                  r_pos       <= w_gap_base;
                  r_pos_valid <= 1'b1;
                  r_pos_last  <= (r_t == TW'(1));
                  r_state     <= S_FILL;
               end else begin
                  r_u        <= w_u;
                  r_in_ready <= 1'b1;
                  r_state    <= S_FLAG;
               end
            end

            S_FLAG: begin
               if (w_in_fire) begin
                  r_i <= '0;
                  r_k <= '0;
                  if (bus.in_bit) begin
                     // Skip a whole gap of 2^u zeros.
                     r_n        <= r_n - w_step;
                     r_delta    <= r_delta + w_step;
                     r_in_ready <= 1'b0;
                     r_state    <= S_CALC;
                  end else if (r_u == '0) begin
                     r_in_ready  <= 1'b0;
                     r_pos       <= w_gap_base;
                     r_pos_valid <= 1'b1;
                     r_pos_last  <= (r_t == TW'(1));
                     r_state     <= S_EMIT;
                  end else begin
                     r_state <= S_INDEX;
                  end
               end
            end

            S_INDEX: begin
               if (w_in_fire) begin
                  r_i <= w_i_shift;
                  if (r_k == NW'(r_u) - NW'(1)) begin
                     r_in_ready  <= 1'b0;
                     r_pos       <= w_gap_base + w_i_shift;
                     r_pos_valid <= 1'b1;
                     r_pos_last  <= (r_t == TW'(1));
                     r_state     <= S_EMIT;
                  end else begin
                     r_k <= r_k + NW'(1);
                  end
               end
            end

            S_EMIT: begin
               if (w_pos_fire) begin
                  r_cw_word   <= r_cw_word | (CW_ONE << r_pos);
                  r_base      <= r_pos + NW'(1);
                  r_n         <= r_n - r_i - NW'(1);
                  r_t         <= r_t - TW'(1);
                  r_delta     <= '0;
                  r_pos_valid <= 1'b0;
                  r_pos_last  <= 1'b0;
                  if (r_t == TW'(1)) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_CALC;
                  end
               end
            end

            S_FILL: begin
               if (w_pos_fire) begin
                  r_cw_word <= r_cw_word | (CW_ONE << r_pos);
                  if (r_k == NW'(r_t) - NW'(1)) begin
                     r_n         <= '0;
                     r_t         <= '0;
                     r_pos_valid <= 1'b0;
                     r_pos_last  <= 1'b0;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_k        <= r_k + NW'(1);
                     r_pos      <= r_pos + NW'(1);
                     r_pos_last <= ((r_k + NW'(2)) == NW'(r_t));
                  end
               end
            end

            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.pos_valid = r_pos_valid;
   assign bus.pos       = r_pos;
   assign bus.pos_last  = r_pos_last;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.cw_word   = r_cw_word;
endmodule
